// File: rtl/window_generator.sv
// window_generator
//   Builds an n x n sliding window over a binary raster-scan image using an
//   external line buffer that stores the previous n-1 rows, one (n-1)-bit
//   word per column.
//
// Ports
//   Clock          : sole clock, rising edge
//   Reset          : asynchronous, active-high; clears window, counters, FSM
//   PixelValid     : Pixel carries a raster-order pixel this cycle
//   Pixel          : binary pixel value
//   LineData       : line-buffer read data at BufAddr (bit 0 = oldest row)
//   BufWriteEnable : line-buffer write strobe (mirrors PixelValid)
//   BufAddr        : line-buffer address = current column
//   Window         : bit r*n+c = row r (0 oldest), column c (n-1 newest)
//   WindowValid    : Window holds a complete in-image neighbourhood
//   FrameDone      : one-cycle pulse after the last pixel of a frame
module window_generator #(
   parameter int AddrWidth   = 3,
   parameter int ImageWidth  = 7,
   parameter int ImageHeight = 5,
   parameter int WindowSize  = 3
) (
   input  logic                               Clock,
   input  logic                               Reset,
   input  logic                               PixelValid,
   input  logic                               Pixel,
   input  logic [WindowSize-2:0]              LineData,
   output logic                               BufWriteEnable,
   output logic [AddrWidth-1:0]               BufAddr,
   output logic [WindowSize*WindowSize-1:0]   Window,
   output logic                               WindowValid,
   output logic                               FrameDone
);

   localparam int N    = WindowSize;
   localparam int RowW = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;

   localparam logic [AddrWidth-1:0] ColLast     = AddrWidth'(ImageWidth - 1);
   localparam logic [AddrWidth-1:0] ColWinStart = AddrWidth'(N - 1);
   localparam logic [RowW-1:0]      RowLast     = RowW'(ImageHeight - 1);
   localparam logic [RowW-1:0]      RowFillEnd  = RowW'(N - 2);

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                 state;
   logic [AddrWidth-1:0]   col;
   logic [RowW-1:0]        row;
   logic [N*N-1:0]         win_p1;
   logic                   vld_p1;
   logic                   done_p1;
   logic [N-1:0]           col_vec;
   logic [N*N-1:0]         win_next;

   // The line buffer is written in the same cycle it is read, so LineData is
   // the pre-write word; the external buffer is responsible for shifting it.
   assign BufWriteEnable = PixelValid;
   assign BufAddr        = col;

   // Newest column: current pixel on top of the buffered rows.
   assign col_vec = {Pixel, LineData};

   always_comb begin
      win_next = win_p1;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N - 1; c++) begin
            win_next[r*N + c] = win_p1[r*N + c + 1];
         end
         win_next[r*N + N - 1] = col_vec[r];
      end
   end

   // Stage p1: window shift, position counters, FSM and registered flags.
   // Columns are never cleared at row wrap; the stale ones are hidden by
   // requiring col >= n-1 before WindowValid is raised.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= FILL;
         col     <= '0;
         row     <= '0;
         win_p1  <= '0;
         vld_p1  <= 1'b0;
         done_p1 <= 1'b0;
      end else begin
         vld_p1  <= 1'b0;
         done_p1 <= 1'b0;
         if (PixelValid) begin
            win_p1 <= win_next;
            vld_p1 <= (state == RUN) && (col >= ColWinStart);
            if (col == ColLast) begin
               col <= '0;
               if (row == RowLast) begin
                  row     <= '0;
                  done_p1 <= 1'b1;
               end else begin
                  row <= row + RowW'(1);
               end
               case (state)
                  FILL:    if (row == RowFillEnd) state <= RUN;
                  RUN:     if (row == RowLast)    state <= FILL;
                  default: state <= FILL;
               endcase
            end else begin
               col <= col + AddrWidth'(1);
            end
         end
      end
   end

   assign Window      = win_p1;
   assign WindowValid = vld_p1;
   assign FrameDone   = done_p1;

endmodule

// File: tb/tb_window_generator.sv
// tb_window_generator
//   Directed bench for window_generator (7x5 image, 3x3 window). A behavioural
//   line buffer sits on the buffer port; expected windows are taken straight
//   from the stored test image at the accepted pixel position.
module tb_window_generator;

   logic       Clock;
   logic       Reset;
   logic       PixelValid;
   logic       Pixel;
   logic [1:0] LineData;
   logic       BufWriteEnable;
   logic [2:0] BufAddr;
   logic [8:0] Window;
   logic       WindowValid;
   logic       FrameDone;

   window_generator #(
      .AddrWidth  (3),
      .ImageWidth (7),
      .ImageHeight(5),
      .WindowSize (3)
   ) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .PixelValid    (PixelValid),
      .Pixel         (Pixel),
      .LineData      (LineData),
      .BufWriteEnable(BufWriteEnable),
      .BufAddr       (BufAddr),
      .Window        (Window),
      .WindowValid   (WindowValid),
      .FrameDone     (FrameDone)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Line buffer: word bit 0 = oldest row, bit 1 = previous row.
   logic [1:0] lbuf [0:7];
   assign LineData = lbuf[BufAddr];
   always @(posedge Clock) begin
      if (BufWriteEnable) lbuf[BufAddr] <= {Pixel, LineData[1]};
   end

   logic img [0:4][0:6];

   int total;
   int bad;
   int trow;
   int tcol;
   int acc_cnt;
   int wv_cnt;
   int fd_cnt;
   int fd_acc [0:3];

   task automatic fill_img(input int mode);
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 7; c++) begin
            case (mode)
               0:       img[r][c] = 1'b1;
               1:       img[r][c] = ((r + c) % 2) == 1;
               default: img[r][c] = ((r*13 + c*7 + r*c) % 5) < 2;
            endcase
         end
      end
   endtask

   task automatic clear_counts();
      trow    = 0;
      tcol    = 0;
      acc_cnt = 0;
      wv_cnt  = 0;
      fd_cnt  = 0;
   endtask

   // One cycle: entered just after a rising edge, leaves just after the next.
   task automatic step(input logic v);
      logic       exp_wv;
      logic       exp_fd;
      logic [8:0] exp_win;
      PixelValid = v;
      Pixel      = v ? img[trow][tcol] : 1'b1;
      #1;
      total++;
      if (BufWriteEnable !== v)
         $display("FAIL buf_we got=%0b want=%0b", BufWriteEnable, v);
      if (BufWriteEnable !== v) bad++;
      total++;
      if (BufAddr !== 3'(tcol)) begin
         $display("FAIL buf_addr got=%0d want=%0d", BufAddr, tcol);
         bad++;
      end
      exp_wv  = v && (trow >= 2) && (tcol >= 2);
      exp_fd  = v && (trow == 4) && (tcol == 6);
      exp_win = '0;
      if (exp_wv) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               exp_win[r*3 + c] = img[trow - 2 + r][tcol - 2 + c];
      end
      @(posedge Clock);
      #1;
      total++;
      if (WindowValid !== exp_wv) begin
         $display("FAIL window_valid row=%0d col=%0d got=%0b want=%0b",
                  trow, tcol, WindowValid, exp_wv);
         bad++;
      end
      total++;
      if (FrameDone !== exp_fd) begin
         $display("FAIL frame_done row=%0d col=%0d got=%0b want=%0b",
                  trow, tcol, FrameDone, exp_fd);
         bad++;
      end
      if (exp_wv) begin
         total++;
         if (Window !== exp_win) begin
            $display("FAIL window row=%0d col=%0d got=%03h want=%03h",
                     trow, tcol, Window, exp_win);
            bad++;
         end
      end
      if (v) begin
         acc_cnt++;
         if (tcol == 6) begin
            tcol = 0;
            trow = (trow == 4) ? 0 : trow + 1;
         end else begin
            tcol++;
         end
      end
      if (WindowValid === 1'b1) wv_cnt++;
      if (FrameDone === 1'b1) begin
         if (fd_cnt < 4) fd_acc[fd_cnt] = acc_cnt;
         fd_cnt++;
      end
   endtask

   task automatic run_frame(input int gap);
      for (int i = 0; i < 35; i++) begin
         step(1'b1);
         for (int g = 0; g < gap; g++) step(1'b0);
      end
   endtask

   task automatic check_counts(input string name, input int want_wv,
                               input int want_fd);
      total++;
      if (wv_cnt !== want_wv) begin
         $display("FAIL %s_wv_count got=%0d want=%0d", name, wv_cnt, want_wv);
         bad++;
      end
      total++;
      if (fd_cnt !== want_fd) begin
         $display("FAIL %s_fd_count got=%0d want=%0d", name, fd_cnt, want_fd);
         bad++;
      end
   endtask

   task automatic test_reset();
      Reset      = 1'b1;
      PixelValid = 1'b1;
      Pixel      = 1'b1;
      #1;
      total++;
      if (BufWriteEnable !== 1'b1) begin
         $display("FAIL reset_we_hi got=%0b want=1", BufWriteEnable);
         bad++;
      end
      @(posedge Clock);
      @(posedge Clock);
      #1;
      total++;
      if (Window !== 9'h000) begin
         $display("FAIL reset_window got=%03h want=000", Window);
         bad++;
      end
      total++;
      if (WindowValid !== 1'b0 || FrameDone !== 1'b0) begin
         $display("FAIL reset_flags got=%0b%0b want=00", WindowValid, FrameDone);
         bad++;
      end
      total++;
      if (BufAddr !== 3'd0) begin
         $display("FAIL reset_addr got=%0d want=0", BufAddr);
         bad++;
      end
      PixelValid = 1'b0;
      #1;
      total++;
      if (BufWriteEnable !== 1'b0) begin
         $display("FAIL reset_we_lo got=%0b want=0", BufWriteEnable);
         bad++;
      end
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      clear_counts();
   endtask

   task automatic test_all_ones();
      fill_img(0);
      clear_counts();
      run_frame(0);
      check_counts("ones", 15, 1);
      total++;
      if (fd_acc[0] !== 35) begin
         $display("FAIL ones_fd_pos got=%0d want=35", fd_acc[0]);
         bad++;
      end
   endtask

   task automatic test_checkerboard();
      fill_img(1);
      clear_counts();
      run_frame(0);
      check_counts("checker", 15, 1);
   endtask

   task automatic test_gaps();
      fill_img(1);
      clear_counts();
      run_frame(2);
      check_counts("gaps", 15, 1);
   endtask

   task automatic test_midframe_reset();
      fill_img(1);
      clear_counts();
      for (int i = 0; i < 20; i++) step(1'b1);
      PixelValid = 1'b0;
      Reset      = 1'b1;
      #1;
      total++;
      if (Window !== 9'h000 || WindowValid !== 1'b0 || FrameDone !== 1'b0) begin
         $display("FAIL async_reset got=%03h/%0b/%0b want=000/0/0",
                  Window, WindowValid, FrameDone);
         bad++;
      end
      total++;
      if (BufAddr !== 3'd0) begin
         $display("FAIL async_reset_addr got=%0d want=0", BufAddr);
         bad++;
      end
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      fill_img(2);
      clear_counts();
      run_frame(0);
      check_counts("midreset", 15, 1);
   endtask

   task automatic test_back_to_back();
      fill_img(2);
      clear_counts();
      run_frame(0);
      run_frame(0);
      check_counts("b2b", 30, 2);
      total++;
      if (fd_acc[1] - fd_acc[0] !== 35) begin
         $display("FAIL b2b_fd_spacing got=%0d want=35", fd_acc[1] - fd_acc[0]);
         bad++;
      end
   endtask

   task automatic test_single_col6();
      fill_img(1);
      clear_counts();
      for (int i = 0; i < 6; i++) step(1'b1);
      step(1'b1);
      PixelValid = 1'b0;
      #1;
      total++;
      if (BufAddr !== 3'd0) begin
         $display("FAIL col6_wrap_addr got=%0d want=0", BufAddr);
         bad++;
      end
      total++;
      if (BufWriteEnable !== 1'b0) begin
         $display("FAIL col6_idle_we got=%0b want=0", BufWriteEnable);
         bad++;
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      Reset      = 1'b1;
      PixelValid = 1'b0;
      Pixel      = 1'b0;
      clear_counts();
      test_reset();
      test_all_ones();
      test_checkerboard();
      test_gaps();
      test_midframe_reset();
      test_back_to_back();
      test_single_col6();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
